// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: forwarding and load-use hazard unit sitting beside the ID/EX boundary.
// Keeps a shadow pipeline of destination tags from EX onward, produces registered
// per-operand forwarding selects for EX and a combinational stall request for ID.
// Optional build macro: FWD_STATS_EN enables the saturating 16-bit stall-cycle counter;
// without it stall_cnt is tied to zero and no counter flops exist.
module fwd_scoreboard #(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  localparam int SELW     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pipe_en,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  output logic                      stall,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic [15:0]               stall_cnt
);

  // Tag entries 0..FWD_DEPTH-1; entry 0 is the EX instruction. The last logical entry
  // (index FWD_DEPTH) can never be matched by a younger reader, so it is not stored.
  logic [FWD_DEPTH-1:0]             validQ;
  logic [FWD_DEPTH-1:0]             regwriteQ;
  logic [FWD_DEPTH-1:0]             isLoadQ;
  logic [FWD_DEPTH-1:0][REG_AW-1:0] rdQ;

  logic [NUM_SRC*SELW-1:0] fwdSelQ;
  logic [NUM_SRC*SELW-1:0] fwdSelD;
  logic [NUM_SRC-1:0]      srcHazard;
  logic [REG_AW-1:0]       srcReg;
  logic                    accept;

  // Per source: scan oldest to youngest so the youngest live match overwrites older ones.
  always_comb begin
    fwdSelD   = '0;
    srcHazard = '0;
    srcReg    = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      srcReg = id_src[s*REG_AW +: REG_AW];
      for (int j = FWD_DEPTH - 1; j >= 0; j--) begin
        if (validQ[j] && regwriteQ[j] && (rdQ[j] != '0) && (rdQ[j] == srcReg)) begin
          fwdSelD[s*SELW +: SELW] = SELW'(j + 1);
          // Load data is not forwardable until it has reached stage LOAD_LAT+1.
          srcHazard[s]            = isLoadQ[j] && (j < LOAD_LAT);
        end
      end
    end
  end

  // Flush wins over stall: a killed instruction never requests a stall.
  always_comb begin
    stall  = id_valid & ~flush & (|srcHazard);
    accept = id_valid & ~flush & ~stall;
  end

  // Advance the tag pipeline and register the selects for the instruction entering EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ    <= '0;
      regwriteQ <= '0;
      isLoadQ   <= '0;
      rdQ       <= '0;
      fwdSelQ   <= '0;
    end else if (pipe_en) begin
      for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
        validQ[k]    <= validQ[k-1];
        regwriteQ[k] <= regwriteQ[k-1];
        isLoadQ[k]   <= isLoadQ[k-1];
        rdQ[k]       <= rdQ[k-1];
      end
      validQ[0]    <= accept;
      regwriteQ[0] <= accept & id_regwrite;
      isLoadQ[0]   <= accept & id_is_load;
      rdQ[0]       <= accept ? id_rd : '0;
      fwdSelQ      <= accept ? fwdSelD : '0;
    end
  end

  assign fwd_sel = fwdSelQ;

`ifdef FWD_STATS_EN
  logic [15:0] stallCntQ;

  // Count cycles in which the pipeline actually advanced while stalled; saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntQ <= '0;
    end else if (pipe_en && stall && (stallCntQ != 16'hFFFF)) begin
      stallCntQ <= stallCntQ + 16'd1;
    end
  end

  assign stall_cnt = stallCntQ;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and load-use hazard unit for the pipelined CPU. It keeps its own shadow pipeline of destination tags for every stage from EX through the last forwarding stage. It produces registered per-operand forwarding selects for the instruction in EX, and a combinational stall request for the instruction in ID. It sits beside the ID/EX boundary and replaces the fixed two-source, two-stage forwarding logic.

## Interface
Parameters:
- `REG_AW`, 5, register-index width
- `NUM_SRC`, 2, source operands per instruction
- `FWD_DEPTH`, 2, producer stages after EX that can forward (1 = EX/MEM, 2 = MEM/WB, ...); legal range ≥1
- `LOAD_LAT`, 1, stage index at which load data becomes forwardable is `LOAD_LAT+1`; legal range `0 ≤ LOAD_LAT < FWD_DEPTH`
- Derived: `SELW = $clog2(FWD_DEPTH+1)`

Ports:
- `clk` in 1: the single clock
- `rst_n` in 1: asynchronous, active-low reset
- `pipe_en` in 1: pipeline advances this cycle; 0 freezes all state
- `flush` in 1: kill the instruction leaving ID
- `id_valid` in 1: ID holds a real instruction
- `id_regwrite` in 1: the ID instruction writes `id_rd`
- `id_is_load` in 1: the ID instruction is a load
- `id_rd` in `REG_AW`: destination register
- `id_src` in `NUM_SRC*REG_AW`: source registers, operand i at `[i*REG_AW +: REG_AW]`
- `stall` out 1: hold PC and IF/ID, inject a bubble into EX
- `fwd_sel` out `NUM_SRC*SELW`: per EX operand; 0 = register file, k = result of stage k
- `stall_cnt` out 16: stall-cycle counter (see Configuration)

## Operation
- Tag pipeline: entries 0..FWD_DEPTH. Entry 0 is the EX instruction. Each entry holds `valid`, `regwrite`, `is_load`, `rd`.
- Live producer: an entry with `valid & regwrite & rd != 0`. Register 0 never matches.
- Stall check, combinational:
  - For each ID source s, find the youngest live entry j in 0..FWD_DEPTH-1 with `rd == s`.
  - `stall = id_valid & !flush & OR over s of (is_load[j] & j < LOAD_LAT)`.
  - Only the youngest match counts. An older entry is shadowed.
- Forward select, computed at ID, registered into EX:
  - Per source, the candidate is the youngest matching j as above. Its select is `j+1`, or 0 if there is no match.
- On a clock edge with `pipe_en = 1`:
  - Entry k ← entry k-1 for k ≥ 1. The old entry FWD_DEPTH is discarded.
  - If `id_valid & !flush & !stall`: entry 0 ← ID tag and `fwd_sel` ← computed selects.
  - Otherwise: entry 0 ← bubble (valid = 0) and `fwd_sel` ← 0.
- With `pipe_en = 0`: all entries, `fwd_sel` and `stall_cnt` hold. `stall` still reflects current state.
- `flush` has priority over `stall`. A flushed instruction never stalls and never enters entry 0.

## Timing
- Reset: all `valid` = 0, `fwd_sel` = 0, `stall_cnt` = 0. Therefore `stall` = 0 after reset.
- Reset asserted mid-operation clears all of the above immediately, with no clock needed.
- `stall`: combinational from ID inputs and entries, same cycle.
- `fwd_sel`: valid for the whole cycle the instruction is in EX, i.e. one edge after ID, with no combinational path from EX.
- Load-use with `LOAD_LAT = 1`: exactly one stall cycle. With a general LOAD_LAT, a dependent instruction immediately behind a load stalls `LOAD_LAT` cycles.
- A stall held across `pipe_en = 0` cycles does not accumulate extra bubbles.

## Configuration
- `FWD_STATS_EN` defined:
  - `stall_cnt` increments on each edge with `pipe_en & stall`.
  - It saturates at 16'hFFFF and does not wrap.
- Not defined: `stall_cnt` is tied to 0 and no counter flops are built.

## Test plan
- Default parameters. Sequence `add r3`, then `sub` reading r3 → sub's `fwd_sel[0] = 1` in EX, `stall = 0`.
- `add r3`, unrelated instruction, then a reader of r3 in operand 1 → that operand's `fwd_sel = 2`. Then `add r3` twice back-to-back, then a reader → `fwd_sel = 1` (youngest wins).
- `lw r5`, then `and` reading r5 → `stall = 1` for one cycle and a bubble enters EX. The and's `fwd_sel[0] = 2` next cycle. With `FWD_STATS_EN`, `stall_cnt = 1`.
- A writer with rd = 0 followed by a reader of r0 → `fwd_sel = 0`. A writer with `id_regwrite = 0` → no match.
- `lw r5` followed by a dependent instruction with `flush = 1` → `stall = 0`, entry 0 becomes a bubble, `fwd_sel = 0`. `pipe_en = 0` for 3 cycles mid-stall → `stall_cnt` unchanged.
- `FWD_DEPTH = 3`, `LOAD_LAT = 2`, a load then a dependent instruction → 2 stall cycles, then `fwd_sel = 3`. Assert `rst_n` low mid-sequence → `stall` and `fwd_sel` go to 0 asynchronously.
